// File: rtl/audio_processor_if.sv
// Host-side bus for audio_processor: input frame and configuration writes,
// combinational output-word read port and the frame-done flag.
interface audio_processor_if #(
    parameter int NUM_WORDS        = 64,
    parameter int SAMPLES_PER_WORD = 32,
    parameter int SAMPLE_W         = 16
);
    localparam int WORD_W = SAMPLES_PER_WORD * SAMPLE_W;
    localparam int WIDX_W = $clog2(NUM_WORDS);
    localparam int NIDX_W = $clog2(NUM_WORDS * SAMPLES_PER_WORD);

    logic              start;
    logic              data_wr_en;
    logic [WIDX_W-1:0] input_index;
    logic [WORD_W-1:0] data_in;
    logic              pitch_shift_wr_en;
    logic [4:0]        pitch_shift_semitones;
    logic              freq_coeff_wr_en;
    logic [NIDX_W-1:0] freq_coeff_index;
    logic [7:0]        freq_coeff_in;
    logic              overdrive_enable_wr_en;
    logic              overdrive_enable_in;
    logic              overdrive_magnitude_wr_en;
    logic [3:0]        overdrive_magnitude;
    logic              tremolo_enable_wr_en;
    logic              tremolo_enable_in;
    logic [WIDX_W-1:0] output_index;
    logic [WORD_W-1:0] data_out;
    logic              done;

    modport master (
        output start, data_wr_en, input_index, data_in,
        output pitch_shift_wr_en, pitch_shift_semitones,
        output freq_coeff_wr_en, freq_coeff_index, freq_coeff_in,
        output overdrive_enable_wr_en, overdrive_enable_in,
        output overdrive_magnitude_wr_en, overdrive_magnitude,
        output tremolo_enable_wr_en, tremolo_enable_in, output_index,
        input  data_out, done
    );

    modport slave (
        input  start, data_wr_en, input_index, data_in,
        input  pitch_shift_wr_en, pitch_shift_semitones,
        input  freq_coeff_wr_en, freq_coeff_index, freq_coeff_in,
        input  overdrive_enable_wr_en, overdrive_enable_in,
        input  overdrive_magnitude_wr_en, overdrive_magnitude,
        input  tremolo_enable_wr_en, tremolo_enable_in, output_index,
        output data_out, done
    );
endinterface

// File: rtl/audio_processor.sv
// Frame audio effects engine: pitch shift -> gain table -> tremolo -> overdrive, one sample per cycle.
// Define TREMOLO_EN to build the tremolo stage; otherwise tremolo is a passthrough.
module audio_processor #(
    parameter int NUM_WORDS        = 64,
    parameter int SAMPLES_PER_WORD = 32,
    parameter int SAMPLE_W         = 16
) (
    input logic              clk,
    input logic              rst,
    audio_processor_if.slave bus
);
    localparam int NUM_SAMPLES = NUM_WORDS * SAMPLES_PER_WORD;
    localparam int WORD_W      = SAMPLES_PER_WORD * SAMPLE_W;
    localparam int N_W         = $clog2(NUM_SAMPLES);
    localparam int K_W         = $clog2(SAMPLES_PER_WORD);
    localparam int CYC_W       = N_W + 1;
    localparam int R_W         = 10;
    localparam int G_W         = 8;
    localparam int GP_W        = SAMPLE_W + G_W + 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state, state_next;
    logic [CYC_W-1:0]   cyc;
    logic               issue;
    logic               cfg_open;
    logic [N_W-1:0]     n;

    logic [WORD_W-1:0]  in_mem  [NUM_WORDS];
    logic [WORD_W-1:0]  out_mem [NUM_WORDS];
    logic [G_W-1:0]     g_tab   [NUM_SAMPLES];

    logic signed [4:0]  semi, semi_c;
    logic [4:0]         lut_idx;
    logic [R_W-1:0]     ratio;
    logic               od_en;
    logic [3:0]         od_mag;

    logic [N_W+R_W-1:0]         pprod;
    logic [N_W-1:0]             src;
    logic signed [SAMPLE_W-1:0] x;
    logic signed [GP_W-1:0]     gprod, gshift;
    logic signed [SAMPLE_W-1:0] g_sat;

    logic                       p1_valid;
    logic [N_W-1:0]             p1_n;
    logic signed [SAMPLE_W-1:0] p1_y;
    logic signed [SAMPLE_W-1:0] t_y, od_y, thr;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.start) state_next = RUN;
            RUN:     if (cyc == CYC_W'(NUM_SAMPLES + 1)) state_next = DONE;
            DONE:    if (bus.start) state_next = RUN;
            default: state_next = IDLE;
        endcase
    end

    // cyc runs 0..NUM_SAMPLES+1: samples issue for the first NUM_SAMPLES counts, the rest drain the pipe.
    always_ff @(posedge clk) begin
        if (rst || state != RUN) cyc <= '0;
        else                     cyc <= cyc + 1'b1;
    end

    assign issue    = (state == RUN) && !cyc[N_W];
    assign n        = cyc[N_W-1:0];
    assign cfg_open = (state != RUN);

    always_ff @(posedge clk) begin
        if (rst) begin
            semi   <= '0;
            od_en  <= 1'b0;
            od_mag <= '0;
        end else if (cfg_open) begin
            if (bus.pitch_shift_wr_en)         semi   <= bus.pitch_shift_semitones;
            if (bus.overdrive_enable_wr_en)    od_en  <= bus.overdrive_enable_in;
            if (bus.overdrive_magnitude_wr_en) od_mag <= bus.overdrive_magnitude;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_WORDS; i++) in_mem[i] <= '0;
        end else if (cfg_open && bus.data_wr_en) begin
            in_mem[bus.input_index] <= bus.data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_SAMPLES; i++) g_tab[i] <= 8'h10;
        end else if (cfg_open && bus.freq_coeff_wr_en) begin
            g_tab[bus.freq_coeff_index] <= bus.freq_coeff_in;
        end
    end

    always_comb begin
        semi_c = semi;
        if (semi > 5'sd12)       semi_c = 5'sd12;
        else if (semi < -5'sd12) semi_c = -5'sd12;
    end

    // round(256 * 2^(s/12)) for s = -12..+12
    assign lut_idx = $unsigned(semi_c) + 5'd12;

    always_comb begin
        case (lut_idx)
            5'd0:  ratio = 10'd128;  5'd1:  ratio = 10'd136;  5'd2:  ratio = 10'd144;
            5'd3:  ratio = 10'd152;  5'd4:  ratio = 10'd161;  5'd5:  ratio = 10'd171;
            5'd6:  ratio = 10'd181;  5'd7:  ratio = 10'd192;  5'd8:  ratio = 10'd203;
            5'd9:  ratio = 10'd215;  5'd10: ratio = 10'd228;  5'd11: ratio = 10'd242;
            5'd12: ratio = 10'd256;  5'd13: ratio = 10'd271;  5'd14: ratio = 10'd287;
            5'd15: ratio = 10'd304;  5'd16: ratio = 10'd323;  5'd17: ratio = 10'd342;
            5'd18: ratio = 10'd362;  5'd19: ratio = 10'd384;  5'd20: ratio = 10'd406;
            5'd21: ratio = 10'd431;  5'd22: ratio = 10'd456;  5'd23: ratio = 10'd483;
            5'd24: ratio = 10'd512;
            default: ratio = 10'd256;
        endcase
    end

    always_comb begin
        pprod  = (N_W+R_W)'(n) * (N_W+R_W)'(ratio);
        src    = N_W'(pprod >> 8);
        x      = in_mem[src[N_W-1:K_W]][int'(src[K_W-1:0]) * SAMPLE_W +: SAMPLE_W];
        gprod  = GP_W'(x) * GP_W'($signed({1'b0, g_tab[n]}));
        gshift = gprod >>> 4;
        if (&gshift[GP_W-1:SAMPLE_W-1] || ~|gshift[GP_W-1:SAMPLE_W-1])
            g_sat = gshift[SAMPLE_W-1:0];
        else if (gshift[GP_W-1])
            g_sat = {1'b1, {(SAMPLE_W-1){1'b0}}};
        else
            g_sat = {1'b0, {(SAMPLE_W-1){1'b1}}};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            p1_valid <= 1'b0;
            p1_n     <= '0;
            p1_y     <= '0;
        end else begin
            p1_valid <= issue;
            p1_n     <= n;
            p1_y     <= g_sat;
        end
    end

`ifdef TREMOLO_EN
    logic                       trem_en;
    logic [6:0]                 tri_v;
    logic signed [SAMPLE_W+9:0] tprod;

    always_ff @(posedge clk) begin
        if (rst)                                     trem_en <= 1'b0;
        else if (cfg_open && bus.tremolo_enable_wr_en) trem_en <= bus.tremolo_enable_in;
    end

    // 255 - p for p >= 128 is the bitwise inverse of the low seven bits.
    always_comb begin
        tri_v = p1_n[7] ? ~p1_n[6:0] : p1_n[6:0];
        tprod = (SAMPLE_W+10)'(p1_y) * (SAMPLE_W+10)'($signed({2'b01, tri_v}));
        t_y   = trem_en ? SAMPLE_W'(tprod >>> 8) : p1_y;
    end
`else
    logic unused_tremolo;
    assign unused_tremolo = ^{bus.tremolo_enable_wr_en, bus.tremolo_enable_in};
    assign t_y = p1_y;
`endif

    always_comb begin
        thr  = $signed({1'b0, {(SAMPLE_W-1){1'b1}}} >> od_mag);
        od_y = t_y;
        if (od_en) begin
            if (t_y > thr)       od_y = thr;
            else if (t_y < -thr) od_y = -thr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_WORDS; i++) out_mem[i] <= '0;
        end else if (p1_valid) begin
            out_mem[p1_n[N_W-1:K_W]][int'(p1_n[K_W-1:0]) * SAMPLE_W +: SAMPLE_W] <= od_y;
        end
    end

    assign bus.data_out = out_mem[bus.output_index];
    assign bus.done     = (state == DONE);
endmodule

// File: tb/tb_audio_processor.sv
// Bench for audio_processor: table of frame scenarios, expected words queued at start and
// compared after done, plus blocked-write, restart and reset-mid-run sequences.
module tb_audio_processor;
    localparam int NW  = 64;
    localparam int SPW = 32;
    localparam int NS  = 2048;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    audio_processor_if bus ();

    audio_processor #(.NUM_WORDS(64), .SAMPLES_PER_WORD(32), .SAMPLE_W(16)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        int       kind;
        int       val;
        logic [4:0] semi;
        bit       od;
        int       mag;
        bit       trem;
        bit       gain5;
        bit       rgain;
        int       spot_n;
        int       spot_v;
    } vec_t;

    vec_t vecs[9];

    int errors = 0;
    int checks = 0;
    int in_s[NS];
    int g_s[NS];
    int semi_s, od_s, mag_s, trem_s;
    logic [511:0] exp_q[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_int(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_word(string name, int w, logic [511:0] act, logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s word %0d: got %h expected %h", name, w, act, exp);
        end
    endtask

    task automatic bus_idle();
        bus.start = 1'b0;
        bus.data_wr_en = 1'b0;
        bus.input_index = '0;
        bus.data_in = '0;
        bus.pitch_shift_wr_en = 1'b0;
        bus.pitch_shift_semitones = '0;
        bus.freq_coeff_wr_en = 1'b0;
        bus.freq_coeff_index = '0;
        bus.freq_coeff_in = '0;
        bus.overdrive_enable_wr_en = 1'b0;
        bus.overdrive_enable_in = 1'b0;
        bus.overdrive_magnitude_wr_en = 1'b0;
        bus.overdrive_magnitude = '0;
        bus.tremolo_enable_wr_en = 1'b0;
        bus.tremolo_enable_in = 1'b0;
        bus.output_index = '0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < NS; i++) begin
            in_s[i] = 0;
            g_s[i]  = 16;
        end
        semi_s = 0;
        od_s   = 0;
        mag_s  = 0;
        trem_s = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_reset();
    endtask

    task automatic load_frame(int kind, int val);
        for (int n = 0; n < NS; n++) begin
            case (kind)
                0:       in_s[n] = n;
                1:       in_s[n] = val;
                2:       in_s[n] = (n == 5) ? 20000 : 1000;
                default: in_s[n] = int'($urandom_range(65535)) - 32768;
            endcase
        end
        for (int w = 0; w < NW; w++) begin
            logic [511:0] word;
            for (int k = 0; k < SPW; k++) word[k*16 +: 16] = 16'(in_s[w*SPW + k]);
            bus.data_wr_en  = 1'b1;
            bus.input_index = 6'(w);
            bus.data_in     = word;
            tick();
        end
        bus.data_wr_en = 1'b0;
    endtask

    task automatic set_cfg(logic [4:0] semi, bit od, int mag, bit trem);
        bus.pitch_shift_wr_en         = 1'b1;
        bus.pitch_shift_semitones     = semi;
        bus.overdrive_enable_wr_en    = 1'b1;
        bus.overdrive_enable_in       = od;
        bus.overdrive_magnitude_wr_en = 1'b1;
        bus.overdrive_magnitude       = 4'(mag);
        bus.tremolo_enable_wr_en      = 1'b1;
        bus.tremolo_enable_in         = trem;
        tick();
        bus.pitch_shift_wr_en         = 1'b0;
        bus.overdrive_enable_wr_en    = 1'b0;
        bus.overdrive_magnitude_wr_en = 1'b0;
        bus.tremolo_enable_wr_en      = 1'b0;
        semi_s = int'($signed(semi));
        od_s   = int'(od);
        mag_s  = mag;
        trem_s = int'(trem);
    endtask

    task automatic set_gain(int idx, int val);
        bus.freq_coeff_wr_en = 1'b1;
        bus.freq_coeff_index = 11'(idx);
        bus.freq_coeff_in    = 8'(val);
        tick();
        bus.freq_coeff_wr_en = 1'b0;
        g_s[idx] = val;
    endtask

    function automatic int model_sample(int n);
        int s, r, src, y, thr;
        s = semi_s;
        if (s > 12)  s = 12;
        if (s < -12) s = -12;
        r   = $rtoi(256.0 * (2.0 ** (real'(s) / 12.0)) + 0.5);
        src = ((n * r) >>> 8) % NS;
        y   = (in_s[src] * g_s[n]) >>> 4;
        if (y > 32767)  y = 32767;
        if (y < -32768) y = -32768;
`ifdef TREMOLO_EN
        if (trem_s != 0) begin
            int p, tv;
            p  = n % 256;
            tv = (p < 128) ? p : 255 - p;
            y  = (y * (128 + tv)) >>> 8;
        end
`endif
        if (od_s != 0) begin
            thr = 32767 >> mag_s;
            if (y > thr)  y = thr;
            if (y < -thr) y = -thr;
        end
        return y;
    endfunction

    task automatic model_push();
        for (int w = 0; w < NW; w++) begin
            logic [511:0] word;
            for (int k = 0; k < SPW; k++) word[k*16 +: 16] = 16'(model_sample(w*SPW + k));
            exp_q.push_back(word);
        end
    endtask

    task automatic push_zeros();
        for (int w = 0; w < NW; w++) exp_q.push_back('0);
    endtask

    task automatic compare_frame(string name);
        for (int w = 0; w < NW; w++) begin
            logic [511:0] exp_w;
            bus.output_index = 6'(w);
            #1;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL %s word %0d: scoreboard empty", name, w);
            end else begin
                exp_w = exp_q.pop_front();
                check_word(name, w, bus.data_out, exp_w);
            end
        end
    endtask

    task automatic read_sample(input int n, output int v);
        logic [15:0] t;
        bus.output_index = 6'(n / SPW);
        #1;
        t = bus.data_out[(n % SPW)*16 +: 16];
        v = int'($signed(t));
    endtask

    task automatic run_frame(string name, bit disturb);
        int cnt;
        model_push();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check_int({name, "_done_clear"}, int'(bus.done), 0);
        cnt = 0;
        while (bus.done !== 1'b1 && cnt < 3000) begin
            if (disturb && cnt == 100) begin
                bus.start = 1'b1;
                bus.data_wr_en = 1'b1;
                bus.input_index = '0;
                bus.data_in = '1;
                bus.freq_coeff_wr_en = 1'b1;
                bus.freq_coeff_index = '0;
                bus.freq_coeff_in = 8'h00;
                bus.pitch_shift_wr_en = 1'b1;
                bus.pitch_shift_semitones = 5'd7;
                bus.overdrive_enable_wr_en = 1'b1;
                bus.overdrive_enable_in = 1'b1;
                bus.overdrive_magnitude_wr_en = 1'b1;
                bus.overdrive_magnitude = 4'd9;
            end
            if (disturb && cnt == 101) bus_idle();
            tick();
            cnt++;
        end
        check_int({name, "_latency"}, cnt, 2050);
        compare_frame(name);
        repeat (3) tick();
        check_int({name, "_done_hold"}, int'(bus.done), 1);
    endtask

    initial begin
        int v;
        bus_idle();
        model_reset();

        vecs[0] = '{0, 0,     5'b00000, 1'b0, 0, 1'b0, 1'b0, 1'b0, 2047, 2047};
        vecs[1] = '{0, 0,     5'b01100, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1500, 952};
        vecs[2] = '{2, 0,     5'b00000, 1'b0, 0, 1'b0, 1'b1, 1'b0, 5,    32767};
        vecs[3] = '{1, -5000, 5'b00000, 1'b1, 4, 1'b0, 1'b0, 1'b0, 0,    -2047};
`ifdef TREMOLO_EN
        vecs[4] = '{1, 1024,  5'b00000, 1'b0, 0, 1'b1, 1'b0, 1'b0, 127,  1020};
`else
        vecs[4] = '{1, 1024,  5'b00000, 1'b0, 0, 1'b1, 1'b0, 1'b0, 127,  1024};
`endif
        vecs[5] = '{0, 0,     5'b11110, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1000, 890};
        vecs[6] = '{0, 0,     5'b01111, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1500, 952};
        vecs[7] = '{0, 0,     5'b10000, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1000, 500};
        vecs[8] = '{3, 0,     5'b00011, 1'b1, 1, 1'b1, 1'b0, 1'b1, -1,   0};

        do_reset();
        check_int("reset_done", int'(bus.done), 0);
        push_zeros();
        compare_frame("reset_out");

        for (int i = 0; i < 9; i++) begin
            string nm;
            nm = $sformatf("vec%0d", i);
            if (vecs[i].rgain)
                for (int n = 0; n < NS; n++) set_gain(n, int'($urandom_range(255)));
            if (vecs[i].gain5) set_gain(5, 32);
            set_cfg(vecs[i].semi, vecs[i].od, vecs[i].mag, vecs[i].trem);
            load_frame(vecs[i].kind, vecs[i].val);
            run_frame(nm, 1'b0);
            if (vecs[i].spot_n >= 0) begin
                read_sample(vecs[i].spot_n, v);
                check_int({nm, "_spot"}, v, vecs[i].spot_v);
            end
            if (vecs[i].gain5) set_gain(5, 16);
        end

        // Writes and a second start during RUN must be ignored; a rerun proves buffers were untouched.
        set_cfg(5'b00010, 1'b0, 0, 1'b0);
        load_frame(0, 0);
        run_frame("blocked_writes", 1'b1);
        run_frame("rerun", 1'b0);

        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (100) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_reset();
        check_int("midrun_done", int'(bus.done), 0);
        push_zeros();
        compare_frame("midrun_out");
        run_frame("after_reset_zero", 1'b0);
        load_frame(0, 0);
        run_frame("after_reset_ramp", 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/audio_processor.md
# audio_processor

Frame-based audio effects engine between the host-side buffer writer and the output reader. It stores one 2048-sample frame of signed 16-bit audio as 64 words of 512 bits. On `start` it applies four stages in a fixed order: pitch shift, per-slot gain table, tremolo and overdrive. It then writes the result to an output frame buffer and raises `done`.

## Interface
Parameters:
- NUM_WORDS, 64, words per frame
- SAMPLES_PER_WORD, 32, samples per 512-bit word
- SAMPLE_W, 16, signed sample width

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  reset; synchronous, active-high
- start  in  1  begin processing the stored frame
- data_wr_en  in  1  write `data_in` to input word `input_index`
- input_index  in  6  input word address
- data_in  in  512  input word; sample k is at bits [16k+15:16k]
- pitch_shift_wr_en  in  1  latch `pitch_shift_semitones`
- pitch_shift_semitones  in  5  two's complement semitones
- freq_coeff_wr_en  in  1  write gain table entry
- freq_coeff_index  in  11  gain table slot, 0..2047
- freq_coeff_in  in  8  unsigned Q4.4 gain
- overdrive_enable_wr_en  in  1  latch `overdrive_enable_in`
- overdrive_enable_in  in  1  overdrive on/off
- overdrive_magnitude_wr_en  in  1  latch `overdrive_magnitude`
- overdrive_magnitude  in  4  clip strength
- tremolo_enable_wr_en  in  1  latch `tremolo_enable_in`
- tremolo_enable_in  in  1  tremolo on/off
- output_index  in  6  output word address
- data_out  out  512  output word, same packing as `data_in`; combinational read
- done  out  1  frame processed

## Operation
- Sample index: n = 32·word + k, range 0..2047.
- States and transitions:
  - IDLE: `start` moves to RUN.
  - RUN: processes n = 0..2047, one sample per cycle, then moves to DONE.
  - DONE: `done` = 1; `start` moves to RUN and clears `done`.
- Input buffer writes and all configuration writes are accepted only in IDLE and DONE; in RUN they are ignored.
- `start` during RUN is ignored.
- Pitch stage:
  - s = semitones, clamped to −12..+12.
  - ratio R = round(256·2^(s/12)), from a 25-entry LUT; R(0)=256, R(+12)=512, R(−12)=128, R(−2)=228, R(+2)=287.
  - Source index src = ((n·R) >> 8) mod 2048; x = in[src].
- Gain stage: y = sat16((x·G[n]) >>> 4), where G is the 2048×8 table.
- Tremolo stage, when enabled:
  - p = n[7:0]; tri = p < 128 ? p : 255 − p.
  - y = (y·(128 + tri)) >>> 8.
  - Gain therefore ranges 0.5..~1.0 with a 256-sample period.
- Overdrive stage, when enabled: thr = 0x7FFF >> magnitude; clip y to [−thr, +thr].
- Result is written to out[n]; out[] is indexed by `output_index`.
- All multiplies are signed and full width before the shift; sat16 clamps to [−32768, 32767].

## Timing
- Reset values:
  - state IDLE, `done` = 0.
  - Input and output buffers all 0; `data_out` = 0.
  - Semitones 0, overdrive off, magnitude 0, tremolo off.
  - Every G entry = 0x10 (unity).
- `data_wr_en` and config writes take effect at the next rising edge.
- Processing:
  - Start plus one frame: RUN begins the cycle after `start`.
  - The sample pipeline is 2 cycles deep.
  - `done` rises exactly 2048 + 2 cycles after `start` is sampled and stays high until the next accepted `start` or `rst`.
- Settings are read live during RUN; they cannot change because writes are blocked.
- `rst` mid-RUN: returns to IDLE next edge with all reset values; partial output is discarded (buffers zeroed).
- `data_out` updates combinationally from `output_index`; it is valid in any state, but is only meaningful in DONE.

## Configuration
- `TREMOLO_EN` defined: tremolo stage present as specified.
- `TREMOLO_EN` undefined:
  - Tremolo stage is a wire passthrough.
  - `tremolo_enable_wr_en` is ignored.
  - Latency and `done` timing are unchanged.

## Test plan
- Passthrough: reset, load ramp in[n] = n, start → `done` after 2050 cycles; out[n] = n for all n.
- Pitch +12: set semitones 5'b01100, ramp input → out[n] = in[(2n) mod 2048], e.g. out[1500] = 952.
- Gain table: G[5] = 0x20, in[5] = 20000, others 1000 → out[5] = 32767 (saturated), out[6] = 1000.
- Overdrive: enable, magnitude 4, constant input −5000 → every out = −2047 (thr 0x07FF).
- Tremolo (`TREMOLO_EN`): enable, constant input 1024 → out[0] = 512, out[127] = 1020, out[255] = 512.
- Reset mid-run: assert `rst` 100 cycles after start → `done` = 0, all `data_out` words 0; a fresh start completes normally.
